// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer handshake, register-file write port,
// bypass lookup for the two register-file read ports, and occupancy.
// slave  = the queue itself, master = the producer / decode side.
interface wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              wb_hold;
    logic              write_en;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read1_reg;
    logic [ADDR_W-1:0] read2_reg;
    logic              read1_hit;
    logic              read2_hit;
    logic [DATA_W-1:0] read1_fwd;
    logic [DATA_W-1:0] read2_fwd;
    logic [CW-1:0]     count;

    modport slave (
        input  in_valid, in_reg, in_data, wb_hold, read1_reg, read2_reg,
        output in_ready, write_en, write_reg, write_data,
               read1_hit, read2_hit, read1_fwd, read2_fwd, count
    );

    modport master (
        output in_valid, in_reg, in_data, wb_hold, read1_reg, read2_reg,
        input  in_ready, write_en, write_reg, write_data,
               read1_hit, read2_hit, read1_fwd, read2_fwd, count
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: buffers results in a DEPTH-entry FIFO and drains them
// in push order as one registered register-file write per cycle.
// Optional feature macro WB_BYPASS_EN: when defined, pending values (FIFO
// entries and the output stage) are forwarded to both read ports; when
// undefined the hit/fwd outputs are tied to zero.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_queue_if.slave   bus
);
    // Pointers carry one extra wrap bit to tell full from empty.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_reg_p1;
    logic [DATA_W-1:0] wr_data_p1;

    // Stage p0: FIFO occupancy and handshake from registered pointers only
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign empty = (wptr == rptr);
    assign cnt   = wptr - rptr;
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & ~bus.wb_hold;

    assign bus.in_ready = ~full;
    assign bus.count    = cnt;

    // Pointer update; wrap modulo 2*DEPTH falls out of the PW-bit adders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // Entry storage; contents are qualified by the pointers so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wptr[IW-1:0]]  <= bus.in_reg;
            mem_data[wptr[IW-1:0]] <= bus.in_data;
        end
    end

    // Stage p1: register-file write port, one strobe per drained entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_reg_p1  <= '0;
            wr_data_p1 <= '0;
        end else if (pop) begin
            wr_vld_p1  <= 1'b1;
            wr_reg_p1  <= mem_reg[rptr[IW-1:0]];
            wr_data_p1 <= mem_data[rptr[IW-1:0]];
        end else begin
            wr_vld_p1  <= 1'b0;
        end
    end

    assign bus.write_en   = wr_vld_p1;
    assign bus.write_reg  = wr_reg_p1;
    assign bus.write_data = wr_data_p1;

`ifdef WB_BYPASS_EN
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic [IW-1:0]     slot;

    // Bypass lookup: start from the output stage, then walk FIFO entries
    // oldest to youngest so the youngest match overrides everything older.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        slot = '0;
        if (wr_vld_p1 && (wr_reg_p1 == bus.read1_reg)) begin
            hit1 = 1'b1;
            fwd1 = wr_data_p1;
        end
        if (wr_vld_p1 && (wr_reg_p1 == bus.read2_reg)) begin
            hit2 = 1'b1;
            fwd2 = wr_data_p1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = rptr[IW-1:0] + IW'(i);
            if (PW'(i) < cnt) begin
                if (mem_reg[slot] == bus.read1_reg) begin
                    hit1 = 1'b1;
                    fwd1 = mem_data[slot];
                end
                if (mem_reg[slot] == bus.read2_reg) begin
                    hit2 = 1'b1;
                    fwd2 = mem_data[slot];
                end
            end
        end
    end

    assign bus.read1_hit = hit1;
    assign bus.read2_hit = hit2;
    assign bus.read1_fwd = fwd1;
    assign bus.read2_fwd = fwd2;
`else
    logic unused_read_idx;

    assign unused_read_idx = ^{bus.read1_reg, bus.read2_reg};
    assign bus.read1_hit   = 1'b0;
    assign bus.read2_hit   = 1'b0;
    assign bus.read1_fwd   = '0;
    assign bus.read2_fwd   = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_wb_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    // Reference model: pending entries in push order plus the write stage.
    logic [ADDR_W-1:0] qreg[$];
    logic [DATA_W-1:0] qdata[$];
    logic              m_en = 1'b0;
    logic [ADDR_W-1:0] m_reg = '0;
    logic [DATA_W-1:0] m_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        qreg.delete();
        qdata.delete();
        m_en   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    // Newest pending value for a register: latest queue entry, else write stage.
    task automatic model_lookup(input logic [ADDR_W-1:0] a, output logic h, output logic [DATA_W-1:0] f);
        h = 1'b0;
        f = '0;
        if (BYP) begin
            if (m_en && m_reg == a) begin
                h = 1'b1;
                f = m_data;
            end
            foreach (qreg[i]) begin
                if (qreg[i] == a) begin
                    h = 1'b1;
                    f = qdata[i];
                end
            end
        end
    endtask

    task automatic check_model();
        logic              h;
        logic [DATA_W-1:0] f;
        chk("in_ready", 64'(bus.in_ready), 64'(qreg.size() < DEPTH));
        chk("count", 64'(bus.count), 64'(qreg.size()));
        chk("write_en", 64'(bus.write_en), 64'(m_en));
        chk("write_reg", 64'(bus.write_reg), 64'(m_reg));
        chk("write_data", 64'(bus.write_data), 64'(m_data));
        model_lookup(bus.read1_reg, h, f);
        chk("read1_hit", 64'(bus.read1_hit), 64'(h));
        chk("read1_fwd", 64'(bus.read1_fwd), 64'(f));
        model_lookup(bus.read2_reg, h, f);
        chk("read2_hit", 64'(bus.read2_hit), 64'(h));
        chk("read2_fwd", 64'(bus.read2_fwd), 64'(f));
    endtask

    // One cycle: drive at the falling edge, compare, advance the model at
    // the rising edge, and return at the next falling edge.
    task automatic step(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                        input logic h, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        logic pushed;
        logic popped;
        bus.in_valid  = v;
        bus.in_reg    = r;
        bus.in_data   = d;
        bus.wb_hold   = h;
        bus.read1_reg = a1;
        bus.read2_reg = a2;
        #1;
        check_model();
        pushed = v && (qreg.size() < DEPTH);
        popped = (qreg.size() > 0) && !h;
        @(posedge clk);
        if (popped) begin
            m_en   = 1'b1;
            m_reg  = qreg.pop_front();
            m_data = qdata.pop_front();
        end else begin
            m_en = 1'b0;
        end
        if (pushed) begin
            qreg.push_back(r);
            qdata.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_reg    = '0;
        bus.in_data   = '0;
        bus.wb_hold   = 1'b0;
        bus.read1_reg = '0;
        bus.read2_reg = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst write_en", 64'(bus.write_en), 64'd0);
        chk("rst write_reg", 64'(bus.write_reg), 64'd0);
        chk("rst write_data", 64'(bus.write_data), 64'd0);
        chk("rst count", 64'(bus.count), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst read1_hit", 64'(bus.read1_hit), 64'd0);
        chk("rst read2_fwd", 64'(bus.read2_fwd), 64'd0);
        rst_n = 1'b1;

        // Single push: stored first, written during the following cycle only.
        step(1'b1, 3'd2, 32'h0000_00AA, 1'b0, '0, '0);
        chk("lat1 count", 64'(bus.count), 64'd1);
        chk("lat1 write_en", 64'(bus.write_en), 64'd0);
        idle(1);
        chk("lat2 write_en", 64'(bus.write_en), 64'd1);
        chk("lat2 write_reg", 64'(bus.write_reg), 64'd2);
        chk("lat2 write_data", 64'(bus.write_data), 64'hAA);
        chk("lat2 count", 64'(bus.count), 64'd0);
        idle(1);
        chk("lat3 write_en", 64'(bus.write_en), 64'd0);

        // Hold fills the FIFO; a fifth offer is refused; release drains in order.
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 3'(k), 32'h10 + 32'(k), 1'b1, '0, '0);
        chk("full in_ready", 64'(bus.in_ready), 64'd0);
        chk("full count", 64'(bus.count), 64'd4);
        step(1'b1, 3'd7, 32'hDEAD, 1'b1, '0, '0);
        chk("refused count", 64'(bus.count), 64'd4);
        for (int k = 1; k <= DEPTH; k++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0);
            chk("drain write_en", 64'(bus.write_en), 64'd1);
            chk("drain write_reg", 64'(bus.write_reg), 64'(k));
        end
        idle(1);

        // Full FIFO with a continuous stream: no write bubbles, order kept.
        for (int k = 0; k < DEPTH; k++) step(1'b1, 3'(k), 32'h200 + 32'(k), 1'b1, '0, '0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 3'(k % 8), 32'h100 + 32'(k), 1'b0, 3'(k % 8), 3'((k + 3) % 8));
            chk("stream write_en", 64'(bus.write_en), 64'd1);
        end
        idle(DEPTH + 1);

        // Youngest pending value wins on read port 1; port 2 has no match.
        step(1'b1, 3'd5, 32'h11, 1'b1, 3'd5, 3'd6);
        step(1'b1, 3'd5, 32'h22, 1'b1, 3'd5, 3'd6);
        step(1'b0, '0, '0, 1'b1, 3'd5, 3'd6);
        chk("byp read1_hit", 64'(bus.read1_hit), 64'(BYP));
        chk("byp read1_fwd", 64'(bus.read1_fwd), BYP ? 64'h22 : 64'h0);
        chk("byp read2_hit", 64'(bus.read2_hit), 64'd0);
        idle(3);

        // Forwarding from the output stage alone, gone the cycle after.
        step(1'b1, 3'd3, 32'h33, 1'b0, '0, 3'd3);
        step(1'b0, '0, '0, 1'b0, '0, 3'd3);
        chk("ostage write_en", 64'(bus.write_en), 64'd1);
        chk("ostage read2_hit", 64'(bus.read2_hit), 64'(BYP));
        chk("ostage read2_fwd", 64'(bus.read2_fwd), BYP ? 64'h33 : 64'h0);
        step(1'b0, '0, '0, 1'b0, '0, 3'd3);
        chk("after read2_hit", 64'(bus.read2_hit), 64'd0);
        chk("after read2_fwd", 64'(bus.read2_fwd), 64'd0);

        // Asynchronous reset mid-operation with a write in flight.
        for (int k = 0; k < 3; k++) step(1'b1, 3'(k + 1), 32'h300 + 32'(k), 1'b1, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        chk("pre-rst write_en", 64'(bus.write_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst count", 64'(bus.count), 64'd0);
        chk("midrst write_en", 64'(bus.write_en), 64'd0);
        chk("midrst write_reg", 64'(bus.write_reg), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0);
            chk("postrst write_en", 64'(bus.write_en), 64'd0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 9) < 7), 3'($urandom), $urandom,
                 1'($urandom_range(0, 9) < 3), 3'($urandom), 3'($urandom));
        end
        idle(DEPTH + 2);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
